ram16x8_bus_master: RTL and testbench
=====================================

Name: ram16x8_bus_master

Overview:
- Upstream controller for the 16x8 single-port RAM with a shared bidirectional data bus.
- Accepts read, write and fill commands on a valid/ready request channel and sequences the RAM strobes (read, write, preset, address) one command at a time.
- Owns the tristate turnaround so the bus is never contended, and returns read data and acks on a valid/ready response channel.

Parameters:
- DATA_W, 8, RAM word width and bus width.
- ADDR_W, 4, RAM address width (16 words).
- TURN_CYC, 1, idle bus cycles inserted after every read before the master may drive the bus again (range 1..3).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; shared with the RAM.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request.
- req_op  in  2  00 read, 01 write, 10 fill (all words to FF), 11 reserved.
- req_addr  in  ADDR_W  target word.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  DATA_W  read data; 0 for write, fill and error responses.
- rsp_err  out  1  reserved op was issued.
- mem_data  inout  DATA_W  RAM bidirectional bus.
- mem_address  out  ADDR_W  RAM address.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe.
- mem_preset  out  1  RAM fill strobe.
- busy  out  1  high in every state except IDLE.

Behaviour:
- RAM protocol driven by this block:
  - The RAM writes mem_data on a clk edge when mem_write=1 and mem_read=0.
  - The RAM drives mem_data combinationally while mem_read=1 and mem_write=0.
  - mem_preset=1 fills all words with FF on a clk edge, with priority over write.
- Reset (reset=0, asynchronous):
  - State goes to IDLE; all strobes, rsp_valid, rsp_err, rsp_rdata, mem_address and busy go to 0.
  - mem_data is released (Z) and req_ready is 1 once reset deasserts.
  - Reset mid-operation aborts the command with no response; a pending rsp_valid is dropped.
- FSM states: IDLE, WR, RD, FILL, TURN, RSP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, register op, addr and wdata, then go to WR, RD or FILL by op.
  - Reserved op goes directly to RSP with rsp_err=1.
- WR (1 cycle):
  - mem_write=1 and mem_address=addr; mem_data is driven with wdata during this cycle only.
  - Next state is RSP with rdata=0.
- RD (1 cycle):
  - mem_read=1, mem_address=addr, bus released.
  - At the closing edge, mem_data is captured into rsp_rdata; next state is TURN.
- TURN:
  - TURN_CYC cycles with all strobes 0 and the bus released, then RSP.
- FILL (1 cycle):
  - mem_preset=1, then RSP with rdata=0.
- RSP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - Handshake edge returns to IDLE and clears rsp_valid and rsp_err on that edge.
- Latency from the accept edge to rsp_valid:
  - write: 2 cycles; fill: 2 cycles; reserved: 1 cycle.
  - read: 2+TURN_CYC cycles.
- Invariants, each checked by assertion:
  - mem_read and mem_write are never both 1.
  - mem_data is driven only in WR.
  - At most one strobe is high per cycle.
  - Strobes and mem_address are registered outputs with no glitches.
  - mem_address holds its last value in non-access states.
- Back-to-back operation:
  - req_ready=0 in every state except IDLE, so sustained throughput is one command per (latency+1) cycles.
  - No request is accepted in the same cycle as a response handshake.
- rsp_ready held low: the FSM stalls in RSP indefinitely; the RAM sees no strobes.
- Address wrap: none needed; ADDR_W covers all 16 words exactly.

Decomposition:
- Shared package ram16x8_pkg holds:
  - op encodings OP_RD=2'b00, OP_WR=2'b01, OP_FILL=2'b10, OP_RSV=2'b11;
  - the FSM state enum;
  - DATA_W and ADDR_W defaults.
- One natural sub-module: ram16x8_bus_tristate.
  - Takes a registered drive-enable and data, and produces the mem_data assign.
  - Keeps bus ownership in one place for lint and assertions.
- The FSM and datapath stay in the top module.

Test Plan:
- Reset then idle: after reset release, req_ready=1, all strobes 0, mem_data=Z, rsp_valid=0.
- Write then read: write addr 5 data A5, then read addr 5 (TURN_CYC=1).
  - Write gets an ack with rdata=00.
  - Read gets rsp_rdata=A5 exactly 3 cycles after accept.
  - Exactly one TURN cycle, with no bus drive between RD and the next WR.
- Fill then read: fill, then read addr 0 and addr F; both return FF and mem_preset pulses for exactly one cycle.
- Response backpressure: issue a read of addr 3 (data 3C) with rsp_ready=0 for 5 cycles.
  - rsp_valid and rsp_rdata=3C stay stable throughout.
  - req_ready=0 throughout and no strobes are issued.
  - The response is released when rsp_ready rises.
- Reserved op: req_op=11 gives rsp_err=1 and rdata=00 one cycle after accept, with no RAM strobe; the next read still works.
- Mid-operation reset: assert reset during TURN of a read.
  - Outputs clear immediately and no response is produced.
  - The RAM is all zeros afterwards; a read of addr 5 returns 00.

Source files
------------

// File: rtl/ram16x8_pkg.sv
// Shared definitions for the 16x8 RAM bus master: op codes, FSM states, default widths.
package ram16x8_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 4;

   localparam logic [1:0] OP_RD   = 2'b00;
   localparam logic [1:0] OP_WR   = 2'b01;
   localparam logic [1:0] OP_FILL = 2'b10;
   localparam logic [1:0] OP_RSV  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WR   = 3'd1,
      ST_RD   = 3'd2,
      ST_FILL = 3'd3,
      ST_TURN = 3'd4,
      ST_RSP  = 3'd5
   } state_e;

endpackage

// File: rtl/ram16x8_bus_tristate.sv
// Sole driver of the shared RAM data bus; drive enable and data come straight from flops.
module ram16x8_bus_tristate #(
   parameter int DATA_W = 8
) (
   input  logic              drv_en,
   input  logic [DATA_W-1:0] drv_data,
   inout  wire  [DATA_W-1:0] bus
);

   // Drive only while enabled, otherwise release so the RAM can own the bus.
   assign bus = drv_en ? drv_data : {DATA_W{1'bz}};

endmodule

// File: rtl/ram16x8_bus_master.sv
// Upstream master for the 16x8 single-port RAM: one command at a time, registered strobes,
// read-to-write bus turnaround, valid/ready request and response channels.
module ram16x8_bus_master
   import ram16x8_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int TURN_CYC = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   inout  wire  [DATA_W-1:0] mem_data,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic              mem_preset,
   output logic              busy
);

   // Turn counter starts at TURN_CYC-1 and counts down to 0 inside TURN.
   localparam logic [1:0] TURN_INIT = 2'(TURN_CYC - 1);

   state_e            state_q, state_d;
   logic [1:0]        turn_cnt_q, turn_cnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              err_q, err_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              req_ready_q, req_ready_d;
   logic              busy_q, busy_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              pre_q, pre_d;
   logic              drv_en_q, drv_en_d;

   // Next-state and registered-output logic; outputs are computed for the state being entered.
   always_comb begin
      state_d     = state_q;
      turn_cnt_d  = turn_cnt_q;
      rdata_d     = rdata_q;
      wdata_d     = wdata_q;
      addr_d      = addr_q;
      err_d       = err_q;
      rsp_valid_d = rsp_valid_q;
      rd_d        = 1'b0;
      wr_d        = 1'b0;
      pre_d       = 1'b0;
      drv_en_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               rdata_d = '0;
               err_d   = 1'b0;
               case (req_op)
                  OP_RD: begin
                     state_d = ST_RD;
                     addr_d  = req_addr;
                     rd_d    = 1'b1;
                  end
                  OP_WR: begin
                     state_d  = ST_WR;
                     addr_d   = req_addr;
                     wdata_d  = req_wdata;
                     wr_d     = 1'b1;
                     drv_en_d = 1'b1;
                  end
                  OP_FILL: begin
                     state_d = ST_FILL;
                     pre_d   = 1'b1;
                  end
                  default: begin
                     state_d     = ST_RSP;
                     err_d       = 1'b1;
                     rsp_valid_d = 1'b1;
                  end
               endcase
            end
         end
         ST_WR, ST_FILL: begin
            state_d     = ST_RSP;
            rsp_valid_d = 1'b1;
         end
         ST_RD: begin
            // RAM drives the bus combinationally while mem_read is high; capture at the closing edge.
            rdata_d    = mem_data;
            state_d    = ST_TURN;
            turn_cnt_d = TURN_INIT;
         end
         ST_TURN: begin
            if (turn_cnt_q == 2'd0) begin
               state_d     = ST_RSP;
               rsp_valid_d = 1'b1;
            end else begin
               turn_cnt_d = turn_cnt_q - 2'd1;
            end
         end
         ST_RSP: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
               err_d       = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      req_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
   end

   // FSM state and all registered outputs; reset aborts any command in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         turn_cnt_q  <= '0;
         rdata_q     <= '0;
         wdata_q     <= '0;
         addr_q      <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         pre_q       <= 1'b0;
         drv_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         turn_cnt_q  <= turn_cnt_d;
         rdata_q     <= rdata_d;
         wdata_q     <= wdata_d;
         addr_q      <= addr_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         pre_q       <= pre_d;
         drv_en_q    <= drv_en_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = err_q;
   assign mem_address = addr_q;
   assign mem_read    = rd_q;
   assign mem_write   = wr_q;
   assign mem_preset  = pre_q;
   assign busy        = busy_q;

   ram16x8_bus_tristate #(.DATA_W(DATA_W)) u_tri (
      .drv_en   (drv_en_q),
      .drv_data (wdata_q),
      .bus      (mem_data)
   );

   a_no_rd_wr: assert property (@(posedge clk) disable iff (!reset) !(rd_q && wr_q));
   a_onehot:   assert property (@(posedge clk) disable iff (!reset) $onehot0({rd_q, wr_q, pre_q}));
   a_drv_wr:   assert property (@(posedge clk) disable iff (!reset) drv_en_q |-> (state_q == ST_WR));
   a_addr_hold: assert property (@(posedge clk) disable iff (!reset)
                                 (state_q != ST_IDLE) |=> $stable(addr_q));

endmodule

// File: tb/tb_ram16x8_bus_master.sv
// Bench for ram16x8_bus_master: behavioural RAM on the shared bus, scoreboard of expected responses.
module tb_ram16x8_bus_master;
   import ram16x8_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_op = 2'b00;
   logic [3:0] req_addr = 4'h0;
   logic [7:0] req_wdata = 8'h00;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   wire  [7:0] mem_data;
   logic [3:0] mem_address;
   logic       mem_read, mem_write, mem_preset, busy;

   logic [7:0] ram [16];
   int tests = 0;
   int fails = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      int         lat;
      int         acc;
   } exp_t;
   exp_t sbq[$];

   ram16x8_bus_master #(.DATA_W(8), .ADDR_W(4), .TURN_CYC(1)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_data(mem_data), .mem_address(mem_address), .mem_read(mem_read),
      .mem_write(mem_write), .mem_preset(mem_preset), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural 16x8 RAM sharing the reset.
   always @(posedge clk or negedge reset) begin
      if (!reset) for (int i = 0; i < 16; i++) ram[i] <= 8'h00;
      else if (mem_preset) for (int i = 0; i < 16; i++) ram[i] <= 8'hFF;
      else if (mem_write && !mem_read) ram[mem_address] <= mem_data;
   end
   assign mem_data = (mem_read && !mem_write) ? ram[mem_address] : 8'hzz;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: invariants every cycle, response compare against the scoreboard head.
   logic prev_v = 1'b0;
   int   first_cyc = 0;
   always @(negedge clk) begin
      #1;
      if (!reset) prev_v = 1'b0;
      else begin
         chk("strobe_onehot", 32'($onehot0({mem_read, mem_write, mem_preset})), 1);
         if (dut.drv_en_q) chk("drive_only_in_wr", mem_write, 1);
         if (rsp_valid) begin
            if (!prev_v) first_cyc = cyc;
            if (sbq.size() == 0) chk("unexpected_rsp", 1, 0);
            else begin
               chk("rsp_rdata", rsp_rdata, sbq[0].rdata);
               chk("rsp_err", rsp_err, sbq[0].err);
               chk("rsp_req_ready_low", req_ready, 0);
               chk("rsp_no_strobe", {mem_read, mem_write, mem_preset, dut.drv_en_q}, 0);
               if (rsp_ready) begin
                  chk("latency", first_cyc - sbq[0].acc + 1, sbq[0].lat);
                  void'(sbq.pop_front());
               end
            end
         end
         prev_v = rsp_valid;
      end
   end

   task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d,
                        input logic [7:0] er, input logic ee, input int lat);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      if (!req_ready) begin chk("req_ready_timeout", 0, 1); return; end
      req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
      sbq.push_back('{er, ee, lat, cyc + 1});
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 100) begin @(negedge clk); n++; end
      if (sbq.size() != 0) begin chk("drain_timeout", sbq.size(), 0); sbq.delete(); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset then idle
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk); #1;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_strobes", {mem_read, mem_write, mem_preset}, 0);
      chk("rst_bus_released", dut.drv_en_q, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_addr", mem_address, 0);

      // Write then read, one TURN cycle between
      issue(OP_WR, 4'h5, 8'hA5, 8'h00, 1'b0, 2);
      #1 chk("wr_strobe", mem_write, 1);
      chk("wr_addr", mem_address, 5);
      issue(OP_RD, 4'h5, 8'h00, 8'hA5, 1'b0, 3);
      #1 chk("rd_strobe", mem_read, 1);
      chk("rd_addr", mem_address, 5);
      @(negedge clk); #1;
      chk("turn_quiet", {mem_read, mem_write, mem_preset, dut.drv_en_q}, 0);
      chk("turn_no_rsp", rsp_valid, 0);
      chk("turn_busy", busy, 1);
      issue(OP_WR, 4'h9, 8'h5A, 8'h00, 1'b0, 2);

      // Fill then read both ends
      issue(OP_FILL, 4'h0, 8'h00, 8'h00, 1'b0, 2);
      #1 chk("fill_preset_on", mem_preset, 1);
      @(negedge clk); #1 chk("fill_preset_off", mem_preset, 0);
      issue(OP_RD, 4'h0, 8'h00, 8'hFF, 1'b0, 3);
      issue(OP_RD, 4'hF, 8'h00, 8'hFF, 1'b0, 3);

      // Response backpressure
      issue(OP_WR, 4'h3, 8'h3C, 8'h00, 1'b0, 2);
      drain();
      rsp_ready = 1'b0;
      issue(OP_RD, 4'h3, 8'h00, 8'h3C, 1'b0, 3);
      repeat (6) @(negedge clk);
      #1;
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 8'h3C);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_pending", sbq.size(), 1);
      rsp_ready = 1'b1;
      drain();

      // Reserved op, then a normal read
      issue(OP_RSV, 4'h7, 8'h11, 8'h00, 1'b1, 1);
      #1 chk("rsv_no_strobe", {mem_read, mem_write, mem_preset}, 0);
      drain();
      issue(OP_RD, 4'h3, 8'h00, 8'h3C, 1'b0, 3);
      drain();

      // Reset during TURN of a read
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_RD; req_addr = 4'h5;
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mrst_rsp_valid", rsp_valid, 0);
      chk("mrst_strobes", {mem_read, mem_write, mem_preset}, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_addr", mem_address, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      #1 chk("mrst_no_rsp", rsp_valid, 0);
      issue(OP_RD, 4'h5, 8'h00, 8'h00, 1'b0, 3);
      drain();

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
